// File: rtl/word_fifo_pkg.sv
// Shared sizing defaults and width helpers for the word FIFO slice.
package word_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one extra bit to represent the full state.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/word_fifo_if.sv
// Producer/consumer handshake bundle for word_fifo.
// WORD_FIFO_HWM_EN adds the high-water-mark status pair.
interface word_fifo_if
    import word_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
`ifdef WORD_FIFO_HWM_EN
    logic [CNT_W-1:0]  hwm;
    logic              hwm_clr;
`endif

`ifdef WORD_FIFO_HWM_EN
    modport master (output in_data, in_valid, out_ready, hwm_clr,
                    input  in_ready, out_data, out_valid, count, hwm);
    modport slave  (input  in_data, in_valid, out_ready, hwm_clr,
                    output in_ready, out_data, out_valid, count, hwm);
`else
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, count);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, count);
`endif

endinterface

// File: rtl/word_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset.
module word_fifo_mem
    import word_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO: pointers, occupancy and registered flags.
// Optional high-water mark enabled by WORD_FIFO_HWM_EN.
module word_fifo
    import word_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input logic        clk,
    input logic        reset,
    word_fifo_if.slave bus
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              nonempty_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rdata;

    // Handshakes use only registered flags, so no ready/valid combinational path.
    assign push = bus.in_valid & ~full_q;
    assign pop  = nonempty_q & bus.out_ready;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Flags are precomputed from next occupancy; both clear to 0 in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            count_q    <= count_nxt;
            full_q     <= (count_nxt == CNT_W'(DEPTH));
            nonempty_q <= (count_nxt != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    word_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.out_data  = rdata;
    assign bus.in_ready  = ~full_q;
    assign bus.out_valid = nonempty_q;
    assign bus.count     = count_q;

`ifdef WORD_FIFO_HWM_EN
    logic [CNT_W-1:0] hwm_q;

    // Tracks the registered count, so it trails occupancy by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hwm_q <= '0;
        end else if (bus.hwm_clr) begin
            hwm_q <= count_q;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end

    assign bus.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_word_fifo.sv
// Directed bench for word_fifo; covers the HWM option when WORD_FIFO_HWM_EN is defined.
module tb_word_fifo;
    import word_fifo_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned DP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    word_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    word_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wv(input int k);
        return 16'(k * 37 + 'h0A00);
    endfunction

    initial begin
        int wi;
        int ri;

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef WORD_FIFO_HWM_EN
        bus.hwm_clr   = 1'b0;
`endif

        // Reset then idle
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
`ifdef WORD_FIFO_HWM_EN
        chk("rst_hwm", 32'(bus.hwm), 0);
`endif

        // Single push into empty FIFO
        bus.in_data  = 16'h1234;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("one_out_valid", 32'(bus.out_valid), 1);
        chk("one_out_data", 32'(bus.out_data), 'h1234);
        chk("one_count", 32'(bus.count), 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("one_drained", 32'(bus.count), 0);

        // Empty: simultaneous push and pop stores the word, no pop happens
        bus.in_data   = 16'hBEEF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        chk("empty_pp_count", 32'(bus.count), 1);
        chk("empty_pp_valid", 32'(bus.out_valid), 1);
        chk("empty_pp_data", 32'(bus.out_data), 'hBEEF);
        tick();
        bus.out_ready = 1'b0;
        chk("empty_pp_drain", 32'(bus.count), 0);

        // Fill to full, refused 9th push, ordered drain
        for (int i = 1; i <= 8; i++) begin
            bus.in_data  = 16'(i);
            bus.in_valid = 1'b1;
            tick();
        end
        chk("full_count", 32'(bus.count), 8);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        bus.in_data = 16'h0009;
        tick();
        bus.in_valid = 1'b0;
        chk("refused_count", 32'(bus.count), 8);
        chk("refused_head", 32'(bus.out_data), 1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(bus.out_data), 32'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_out_valid", 32'(bus.out_valid), 0);

        // Full with push and pop together: pop only, push retried next cycle
        for (int i = 1; i <= 8; i++) begin
            bus.in_data  = 16'(32'h10 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_data   = 16'h00AA;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("fullpp_count", 32'(bus.count), 7);
        chk("fullpp_in_ready", 32'(bus.in_ready), 1);
        chk("fullpp_head", 32'(bus.out_data), 'h12);
        tick();
        bus.in_valid = 1'b0;
        chk("retry_count", 32'(bus.count), 8);
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("fullpp_drain", 32'(bus.out_data), 32'(32'h10 + i));
            tick();
        end
        chk("fullpp_last", 32'(bus.out_data), 'hAA);
        tick();
        bus.out_ready = 1'b0;
        chk("fullpp_empty", 32'(bus.count), 0);

        // Stream 100 words at steady occupancy 3
        wi = 0;
        ri = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = wv(wi);
            bus.in_valid = 1'b1;
            tick();
            wi++;
        end
        chk("stream_prime", 32'(bus.count), 3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 97; i++) begin
            bus.in_data = wv(wi);
            chk("stream_data", 32'(bus.out_data), 32'(wv(ri)));
            tick();
            wi++;
            ri++;
            chk("stream_count", 32'(bus.count), 3);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stream_tail", 32'(bus.out_data), 32'(wv(ri)));
            tick();
            ri++;
        end
        bus.out_ready = 1'b0;
        chk("stream_empty", 32'(bus.count), 0);

        // Reset mid-operation discards contents
        for (int i = 0; i < 4; i++) begin
            bus.in_data  = 16'(32'h40 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_count", 32'(bus.count), 4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);

`ifdef WORD_FIFO_HWM_EN
        // High-water mark: peak of 5, then clear loads current count 0
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 16'(32'h50 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("hwm_fill_count", 32'(bus.count), 5);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        bus.out_ready = 1'b0;
        tick();
        chk("hwm_drain_count", 32'(bus.count), 0);
        chk("hwm_peak", 32'(bus.hwm), 5);
        bus.hwm_clr = 1'b1;
        tick();
        bus.hwm_clr = 1'b0;
        chk("hwm_clr", 32'(bus.hwm), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/word_fifo.md
WORD_FIFO -- requirements
Module: word_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries; it SHALL be a power of two, minimum 2.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-low reset; clock clk.
REQ-005 Port in_data  input  DATA_W  write word from the producer.
REQ-006 Port in_valid  input  1  producer offers in_data.
REQ-007 Port in_ready  output  1  FIFO accepts the word this cycle.
REQ-008 Port out_data  output  DATA_W  head word, feeding the downstream 16-bit register stage.
REQ-009 Port out_valid  output  1  out_data holds a valid head word.
REQ-010 Port out_ready  input  1  consumer takes the head word this cycle.
REQ-011 Port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-013 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-015 out_valid SHALL equal (count != 0) and SHALL NOT depend combinationally on in_valid.
REQ-016 The FIFO SHALL be first-word-fall-through: out_data SHALL show the oldest stored word whenever out_valid=1.
REQ-017 A word pushed at edge N SHALL be visible at out_data with out_valid=1 after edge N, provided the FIFO was empty; latency is 1 cycle.
REQ-018 count SHALL change by +1 on a push only, by -1 on a pop only, and by 0 on a simultaneous push and pop.
REQ-019 When full, no push SHALL occur, even if a pop happens in the same cycle; the producer retries on the next cycle.
REQ-020 When empty, no pop SHALL occur; a same-cycle push SHALL be stored, and out_valid SHALL rise on the next cycle.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-022 out_data SHALL be don't-care while out_valid=0; the bench SHALL NOT check it then.
REQ-023 Data SHALL pass through unmodified, bit-exact, in FIFO order.

Reset
REQ-024 While reset=0 at a rising edge:
- count, both pointers and every status register SHALL clear to 0.
- out_valid SHALL be 0 and in_ready SHALL be 1 on the following cycle.
REQ-025 Reset asserted mid-operation SHALL discard all stored words.
REQ-026 The storage array itself SHALL NOT require reset.

Configuration
REQ-027 Macro WORD_FIFO_HWM_EN, when defined, SHALL add output hwm (width $clog2(DEPTH)+1) and input hwm_clr (1 bit).
REQ-028 With the macro defined:
- hwm SHALL hold the peak value of count since the last reset or hwm_clr.
- hwm SHALL update one cycle after count changes.
- hwm_clr=1 SHALL load hwm with the current count.
- hwm SHALL reset to 0.
REQ-029 Without the macro, hwm and hwm_clr SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package word_fifo_pkg SHALL hold the DATA_W and DEPTH defaults and a localparam/function for pointer width and count width.
REQ-031 Storage SHALL sit in sub-module word_fifo_mem: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
REQ-032 Control logic (pointers, count, flags, hwm) SHALL remain in word_fifo.

Verification
REQ-033 Reset then idle -> count=0, out_valid=0, in_ready=1; with the macro, hwm=0.
REQ-034 Push 0x1234 into an empty FIFO with out_ready=0 -> next cycle out_valid=1, out_data=0x1234, count=1.
REQ-035 Push 8 words 0x0001..0x0008 with out_ready=0 -> count=8 and in_ready=0; a 9th push of 0x0009 is refused; draining returns 0x0001..0x0008 in order.
REQ-036 Full FIFO with in_valid=1 and out_ready=1 held for 1 cycle -> pop only, count=7; the next cycle the push is accepted and count=8.
REQ-037 Stream 100 words with continuous push and pop at count=3 -> count stays 3, pointers wrap at least 12 times, and the output sequence matches the input sequence.
REQ-038 With the macro: fill to 5, drain to 0 -> hwm=5; pulse hwm_clr -> hwm=0. Separately, assert reset with count=4 -> count=0 and out_valid=0 on the next cycle.
